// File: rtl/contador_descendente_n_bits_pkg.sv
// contador_pkg: shared FSM state type and active-low hex glyph table for the down-counter.
package contador_pkg;
  typedef enum logic [1:0] {IDLE, RUNNING, DONE} estado_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/contador_descendente_n_bits_if.sv
// contador_descendente_n_bits_if: control, count and display signals of the down-counter.
interface contador_descendente_n_bits_if #(parameter int N = 4) ();
  logic load;
  logic [N-1:0] loadValue;
  logic start;
  logic stop;
  logic enable;
  logic [N-1:0] registroContador;
  logic busy;
  logic terminalCount;
  logic finished;
  logic [6:0] sSegment1;
  logic [6:0] sSegment2;
  modport master (
    output load, loadValue, start, stop, enable,
    input registroContador, busy, terminalCount, finished, sSegment1, sSegment2
  );
  modport slave (
    input load, loadValue, start, stop, enable,
    output registroContador, busy, terminalCount, finished, sSegment1, sSegment2
  );
endinterface

// File: rtl/contador_descendente_n_bits_decodificador_7seg.sv
// decodificador_7seg: 4-bit value to active-low {g..a} hex glyph.
module decodificador_7seg
  import contador_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);
  assign segments = HEX_GLYPH[nibble];
endmodule

// File: rtl/contador_descendente_n_bits.sv
// contador_descendente_n_bits: loadable N-bit down-counter with IDLE/RUNNING/DONE FSM and two hex displays.
// Define AUTO_RELOAD_EN to make reaching zero while RUNNING reload the count and keep running.
module contador_descendente_n_bits
  import contador_pkg::*;
#(parameter int N = 4)
(
  input logic clock,
  input logic reset,
  contador_descendente_n_bits_if.slave bus
);
  estado_t stateReg, stateNext;
  logic [N-1:0] countReg, countNext, reloadReg, reloadNext;
  logic tcReg, tcNext;
  logic [7:0] countWide;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg  <= IDLE;
      countReg  <= '0;
      reloadReg <= '0;
      tcReg     <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      countReg  <= countNext;
      reloadReg <= reloadNext;
      tcReg     <= tcNext;
    end
  end
  // load > stop > start > enable
  always_comb begin
    stateNext  = stateReg;
    countNext  = countReg;
    reloadNext = reloadReg;
    tcNext     = 1'b0;
    if (bus.load) begin
      countNext  = bus.loadValue;
      reloadNext = bus.loadValue;
      stateNext  = IDLE;
    end else begin
      unique case (stateReg)
        IDLE: if (bus.start) begin
          stateNext = (countReg != '0) ? RUNNING : DONE;
          tcNext    = (countReg == '0);
        end
        RUNNING: if (bus.stop) stateNext = IDLE;
          else if (bus.enable && countReg == N'(1)) begin
            tcNext = 1'b1;
`ifdef AUTO_RELOAD_EN
            countNext = reloadReg;
`else
            countNext = '0;
            stateNext = DONE;
`endif
          end else if (bus.enable && countReg > N'(1)) countNext = countReg - N'(1);
        DONE: tcNext = bus.start;
        default: stateNext = IDLE;
      endcase
    end
  end
  always_comb begin
    bus.busy     = (stateReg == RUNNING);
    bus.finished = (stateReg == DONE);
  end
  assign bus.registroContador = countReg;
  assign bus.terminalCount    = tcReg;
  assign countWide = 8'(countReg);
  decodificador_7seg uLow  (.nibble(countWide[3:0]), .segments(bus.sSegment1));
  decodificador_7seg uHigh (.nibble(countWide[7:4]), .segments(bus.sSegment2));
endmodule

// File: tb/tb_contador_descendente_n_bits.sv
// tb_contador_descendente_n_bits: directed checks of the N=4 down-counter; AUTO_RELOAD_EN selects the periodic-timer checks.
module tb_contador_descendente_n_bits;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  contador_descendente_n_bits_if #(.N(4)) bus ();
  contador_descendente_n_bits #(.N(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic verificar(input string tag, input logic [31:0] obtenido, input logic [31:0] esperado);
    total++;
    if (obtenido !== esperado) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obtenido, esperado);
    end
  endtask
  task automatic paso();
    @(posedge clock);
    #1;
  endtask
  task automatic estado(input string tag, input logic [3:0] cnt, input logic b, input logic tc, input logic fin);
    verificar({tag, ".count"}, 32'(bus.registroContador), 32'(cnt));
    verificar({tag, ".busy"}, 32'(bus.busy), 32'(b));
    verificar({tag, ".tc"}, 32'(bus.terminalCount), 32'(tc));
    verificar({tag, ".finished"}, 32'(bus.finished), 32'(fin));
  endtask
  initial begin
    bus.load = 0; bus.loadValue = 0; bus.start = 0; bus.stop = 0; bus.enable = 0;
    #2;
    estado("rst", 4'd0, 0, 0, 0);
    verificar("rst.seg1", 32'(bus.sSegment1), 32'(7'b1000000));
    verificar("rst.seg2", 32'(bus.sSegment2), 32'(7'b1000000));
    paso();
    reset = 0;
    bus.load = 1; bus.loadValue = 4'd9; paso();
    estado("t1.load", 4'd9, 0, 0, 0);
    bus.load = 0; bus.start = 1; paso();
    estado("t1.start", 4'd9, 1, 0, 0);
    bus.start = 0; bus.enable = 1;
    repeat (3) paso();
    estado("t1.run", 4'd6, 1, 0, 0);
    reset = 1; #1;
    estado("t1.async", 4'd0, 0, 0, 0);
    verificar("t1.seg1", 32'(bus.sSegment1), 32'(7'b1000000));
    verificar("t1.seg2", 32'(bus.sSegment2), 32'(7'b1000000));
    reset = 0; bus.enable = 0;
`ifndef AUTO_RELOAD_EN
    bus.load = 1; bus.loadValue = 4'd3; paso();
    bus.load = 0; bus.start = 1; paso();
    estado("t2.start", 4'd3, 1, 0, 0);
    bus.start = 0; bus.enable = 1;
    paso(); estado("t2.c2", 4'd2, 1, 0, 0);
    paso(); estado("t2.c1", 4'd1, 1, 0, 0);
    paso(); estado("t2.c0", 4'd0, 0, 1, 1);
    paso(); estado("t2.after", 4'd0, 0, 0, 1);
    repeat (10) paso();
    estado("t2.hold", 4'd0, 0, 0, 1);
`else
    bus.load = 1; bus.loadValue = 4'd2; paso();
    bus.load = 0; bus.start = 1; paso();
    estado("t6.start", 4'd2, 1, 0, 0);
    bus.start = 0; bus.enable = 1;
    paso(); estado("t6.c1a", 4'd1, 1, 0, 0);
    paso(); estado("t6.wrap1", 4'd2, 1, 1, 0);
    paso(); estado("t6.c1b", 4'd1, 1, 0, 0);
    paso(); estado("t6.wrap2", 4'd2, 1, 1, 0);
    bus.enable = 0;
`endif
    bus.enable = 0; bus.load = 1; bus.loadValue = 4'd5; paso();
    bus.load = 0; bus.start = 1; paso();
    estado("t3.start", 4'd5, 1, 0, 0);
    bus.start = 0; bus.enable = 1; paso();
    estado("t3.en1", 4'd4, 1, 0, 0);
    bus.enable = 0; paso();
    estado("t3.en0", 4'd4, 1, 0, 0);
    bus.enable = 1; paso();
    estado("t3.en1b", 4'd3, 1, 0, 0);
    bus.stop = 1; paso();
    estado("t3.stop", 4'd3, 0, 0, 0);
    bus.stop = 0;
    repeat (3) paso();
    estado("t3.idle", 4'd3, 0, 0, 0);
    bus.enable = 0; bus.start = 1; paso();
    bus.start = 0; bus.enable = 1; paso();
    estado("t4.run", 4'd2, 1, 0, 0);
    bus.load = 1; bus.loadValue = 4'd7; bus.start = 1; paso();
    estado("t4.load", 4'd7, 0, 0, 0);
    verificar("t4.seg1", 32'(bus.sSegment1), 32'(7'b1111000));
    bus.load = 0; bus.start = 0; paso();
    estado("t4.idle", 4'd7, 0, 0, 0);
    bus.start = 1; paso();
    estado("t4.restart", 4'd7, 1, 0, 0);
    bus.start = 0; paso();
    estado("t4.dec", 4'd6, 1, 0, 0);
    bus.enable = 0; bus.load = 1; bus.loadValue = 4'd0; paso();
    estado("t5.load0", 4'd0, 0, 0, 0);
    bus.load = 0; bus.start = 1; paso();
    estado("t5.zero", 4'd0, 0, 1, 1);
    bus.start = 0; paso();
    estado("t5.done", 4'd0, 0, 0, 1);
    bus.start = 1; paso();
    estado("t5.repulse", 4'd0, 0, 1, 1);
    bus.start = 0; bus.load = 1; bus.loadValue = 4'hA; paso();
    estado("t5.loadA", 4'hA, 0, 0, 0);
    verificar("t5.seg1A", 32'(bus.sSegment1), 32'(7'b0001000));
    verificar("t5.seg2A", 32'(bus.sSegment2), 32'(7'b1000000));
    bus.loadValue = 4'hF; paso();
    verificar("t5.seg1F", 32'(bus.sSegment1), 32'(7'b0001110));
    bus.load = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/contador_descendente_n_bits.md
Name: contador_descendente_n_bits

Overview:
- Loadable N-bit down-counter, the count-down counterpart to the existing up-counter (`contadorN_bits`).
- Small FSM (`IDLE`/`RUNNING`/`DONE`) gated by a count-enable strobe.
- Emits a terminal-count pulse on reaching zero.
- Drives two active-low seven-segment digits showing the current count in hex.
- Used as the lab's countdown timer core on the board displays.

Parameters:
- N, 4, counter width in bits; legal range 1..8 (two hex digits displayed).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- load  input  1  synchronous load strobe; highest priority after reset
- loadValue  input  N  value captured on load
- start  input  1  begin counting from IDLE
- stop  input  1  abort RUNNING back to IDLE, count held
- enable  input  1  count-enable strobe; one decrement per clock with enable=1 while RUNNING
- registroContador  output  N  current count
- busy  output  1  high while in RUNNING
- terminalCount  output  1  one-cycle pulse on the transition to zero
- finished  output  1  level, high while in DONE
- sSegment1  output  7  active-low segments {g..a}, low nibble of registroContador
- sSegment2  output  7  active-low segments {g..a}, high nibble (zero-extended; bits above N are 0)

Behaviour:
- Reset (async, active-high, takes effect immediately):
  - registroContador=0, reload register=0, state=IDLE.
  - busy=0, terminalCount=0, finished=0.
  - sSegment1=sSegment2=7'b1000000 ("0").
- All other state changes occur on the rising edge of clock.
- Priority per cycle: load > stop > start > enable.
- load (any state): registroContador<=loadValue, reload register<=loadValue, state<=IDLE, terminalCount=0. A start in the same cycle is ignored.
- IDLE:
  - start=1 with count!=0 -> RUNNING next cycle. No decrement in the start cycle.
  - start=1 with count==0 -> DONE, with terminalCount pulsed that cycle.
  - enable is ignored in IDLE.
- RUNNING:
  - enable=1 and count>1: count<=count-1.
  - enable=1 and count==1: count<=0, state<=DONE, terminalCount=1 for exactly that one clock (registered, asserted in the cycle count reads 0).
  - enable=0: hold.
  - stop=1: state<=IDLE, count held.
  - start is ignored in RUNNING.
- DONE:
  - count holds at 0, finished=1.
  - start=1 -> re-pulse terminalCount, stay DONE.
  - Only load (or reset) leaves DONE.
- No wrap-around below 0 without the optional feature; decrement never underflows.
- busy/finished are decoded from state (Moore). terminalCount is a registered Mealy-free pulse.
- Seven-segment outputs are combinational from registroContador.
- Hex glyphs 0-F use standard DE-board active-low encoding, e.g. "1"=7'b1111001, "A"=7'b0001000.

Optional Feature:
- Macro: AUTO_RELOAD_EN.
- Defined: in RUNNING, when enable=1 and count==1:
  - terminalCount pulses for one clock.
  - count<=reload register.
  - state stays RUNNING (periodic timer).
  - DONE is reachable only via start with count==0.
- Undefined: behaviour exactly as above (one-shot, stops in DONE). No reload path is synthesized; the reload register is still kept for load visibility.

Decomposition:
- Package contador_pkg:
  - typedef enum logic [1:0] {IDLE, RUNNING, DONE} estado_t.
  - Constant array of sixteen 7-bit active-low hex glyphs.
  - Localparam SEG_BLANK=7'b1111111.
- Sub-module decodificador_7seg: 4-bit in -> 7-bit active-low out, purely combinational, instantiated twice.

Test Plan:
1. Reset mid-count: N=4, load 9, start, enable=1 for 3 clocks (count=6), assert reset between edges -> count=0, busy=0, finished=0, segments=7'b1000000 immediately.
2. One-shot: load 3, start, enable=1 continuously -> counts 3,2,1,0 on successive edges; terminalCount high exactly one cycle with count=0; finished=1; count stays 0 for 10 further enabled clocks.
3. Enable gating/stop: load 5, start, enable toggling 1/0 -> decrement only on enable cycles; assert stop at count=3 -> IDLE, count=3 held, enable ignored.
4. Priority: load 7 and start in the same cycle while RUNNING at count 2 -> count=7, state IDLE, busy=0; a later start alone -> RUNNING.
5. Zero start and display: load 0, start -> DONE with terminalCount pulse; load 4'hA -> sSegment1=7'b0001000, sSegment2=7'b1000000.
6. AUTO_RELOAD_EN build: load 2, start, enable=1 -> sequence 2,1,2,1,... with terminalCount pulse at each wrap; busy stays 1, finished stays 0.
